uibi_copy_master: RTL and testbench

//  UIBI bus initiator: copies LEN 32-bit words from SRC to DST, one read then one write per word.

---
 rtl/uibi_copy_master.sv | 200 ++++++++++++++++++++
 tb/tb_uibi_copy_master.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uibi_copy_master.sv
// -----------------------------------------------------------------------------
// uibi_copy_master
//   UIBI bus initiator that copies `len` 32-bit words from src_addr to
//   dst_addr, issuing one read followed by one write per word. It sits beside
//   the CPU as a second master behind the bus arbiter and raises a sticky
//   `intr` flag when a copy completes.
//
// Ports
//   clk, rst          system clock, asynchronous active-low reset
//   start             1-cycle command strobe, only honoured in IDLE
//   src_addr/dst_addr word-aligned byte addresses of the source/destination
//   len               number of words to copy (0 completes with no bus traffic)
//   abort             cancels a transfer in progress
//   intr_clr          clears the sticky completion flag
//   busy              high whenever the engine is not IDLE
//   done / err        1-cycle pulses: completion / misalignment or timeout
//   intr              sticky completion flag, set together with done
//   m_bus_*           UIBI master request/ready/data interface
// -----------------------------------------------------------------------------
module uibi_copy_master #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned LEN_W     = 16,
   parameter int unsigned TIMEOUT   = 255,
   parameter logic [1:0]  WORD_MODE = 2'b10
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [XLEN-1:0] src_addr,
   input  logic [XLEN-1:0] dst_addr,
   input  logic [LEN_W-1:0] len,
   input  logic            abort,
   input  logic            intr_clr,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic            intr,
   output logic            m_bus_req,
   output logic            m_bus_wen,
   output logic [1:0]      m_bus_mode,
   output logic [XLEN-1:0] m_bus_addr,
   output logic [XLEN-1:0] m_bus_dat_o,
   input  logic [XLEN-1:0] m_bus_dat_i,
   input  logic            m_bus_ready
);

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_DATA,
      WR_REQ,
      FIN
   } state_t;

   state_t            state;
   logic [XLEN-1:0]   src_q;
   logic [XLEN-1:0]   dst_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  idx;
   logic [LEN_W-1:0]  idx_nxt;
   logic [XLEN-1:0]   word_buf;
   logic [31:0]       wait_cnt;
   logic              wait_hit;
   logic              accept;

   // Byte offset of word `i`; wraps modulo 2^XLEN together with the base.
   function automatic logic [XLEN-1:0] word_off(input logic [LEN_W-1:0] i);
      return XLEN'({i, 2'b00});
   endfunction

   assign m_bus_mode  = WORD_MODE;
   assign m_bus_dat_o = word_buf;
   assign idx_nxt     = idx + 1'b1;
   assign accept      = m_bus_req && m_bus_ready;

   // Wait counter holds the number of already-unaccepted cycles, so the
   // TIMEOUT-th refused cycle is the one where it equals TIMEOUT-1.
   assign wait_hit = (TIMEOUT != 0) && (wait_cnt == 32'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         src_q      <= '0;
         dst_q      <= '0;
         len_q      <= '0;
         idx        <= '0;
         word_buf   <= '0;
         wait_cnt   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         intr       <= 1'b0;
         m_bus_req  <= 1'b0;
         m_bus_wen  <= 1'b0;
         m_bus_addr <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         // A completion set further down overrides this clear.
         if (intr_clr) intr <= 1'b0;

         if ((state != IDLE) && abort) begin
            // An accept coinciding with abort finishes at the slave but the
            // word index is deliberately left unchanged.
            state     <= IDLE;
            busy      <= 1'b0;
            m_bus_req <= 1'b0;
            m_bus_wen <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     src_q <= src_addr;
                     dst_q <= dst_addr;
                     len_q <= len;
                     idx   <= '0;
                     if ((src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00)) begin
                        err <= 1'b1;
                     end else if (len == '0) begin
                        state <= FIN;
                        busy  <= 1'b1;
                        done  <= 1'b1;
                        intr  <= 1'b1;
                     end else begin
                        state      <= RD_REQ;
                        busy       <= 1'b1;
                        m_bus_req  <= 1'b1;
                        m_bus_wen  <= 1'b0;
                        m_bus_addr <= src_addr;
                        wait_cnt   <= '0;
                     end
                  end
               end

               RD_REQ: begin
                  if (accept) begin
                     state     <= RD_DATA;
                     m_bus_req <= 1'b0;
                  end else if (wait_hit) begin
                     state     <= IDLE;
                     busy      <= 1'b0;
                     m_bus_req <= 1'b0;
                     err       <= 1'b1;
                  end else begin
                     wait_cnt <= wait_cnt + 1'b1;
                  end
               end

               RD_DATA: begin
                  word_buf   <= m_bus_dat_i;
                  state      <= WR_REQ;
                  m_bus_req  <= 1'b1;
                  m_bus_wen  <= 1'b1;
                  m_bus_addr <= dst_q + word_off(idx);
                  wait_cnt   <= '0;
               end

               WR_REQ: begin
                  if (accept) begin
                     idx <= idx_nxt;
                     if (idx_nxt == len_q) begin
                        state     <= FIN;
                        m_bus_req <= 1'b0;
                        m_bus_wen <= 1'b0;
                        done      <= 1'b1;
                        intr      <= 1'b1;
                     end else begin
                        state      <= RD_REQ;
                        m_bus_wen  <= 1'b0;
                        m_bus_addr <= src_q + word_off(idx_nxt);
                        wait_cnt   <= '0;
                     end
                  end else if (wait_hit) begin
                     state     <= IDLE;
                     busy      <= 1'b0;
                     m_bus_req <= 1'b0;
                     m_bus_wen <= 1'b0;
                     err       <= 1'b1;
                  end else begin
                     wait_cnt <= wait_cnt + 1'b1;
                  end
               end

               FIN: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end

               default: begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  m_bus_req <= 1'b0;
                  m_bus_wen <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uibi_copy_master.sv
// -----------------------------------------------------------------------------
// tb_uibi_copy_master
//   Directed bench for uibi_copy_master. A behavioural UIBI slave backs the
//   bus with a sparse memory whose unwritten words read as pattern(addr).
//   Expected bus transactions are queued when a copy is launched and popped
//   as the DUT's requests are accepted.
// -----------------------------------------------------------------------------
module tb_uibi_copy_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] src_addr;
   logic [31:0] dst_addr;
   logic [15:0] len;
   logic        abort;
   logic        intr_clr;
   logic        busy, done, err, intr;
   logic        m_bus_req, m_bus_wen;
   logic [1:0]  m_bus_mode;
   logic [31:0] m_bus_addr, m_bus_dat_o, m_bus_dat_i;
   logic        m_bus_ready;
   logic        ready_r = 1'b1;
   logic        force_low = 1'b0;

   int total = 0;
   int bad = 0;
   int rmode = 0;
   int done_cnt = 0, err_cnt = 0, req_cyc = 0, busy_cyc = 0;
   bit sb_en = 1'b1;

   typedef struct {
      logic        wen;
      logic [31:0] addr;
      logic [31:0] dat;
   } xact_t;
   xact_t sbq[$];
   xact_t x;

   logic [31:0] mem [logic [31:0]];

   always #5 clk = ~clk;

   uibi_copy_master #(
      .XLEN(32), .LEN_W(16), .TIMEOUT(255), .WORD_MODE(2'b10)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
      .len(len), .abort(abort), .intr_clr(intr_clr), .busy(busy), .done(done),
      .err(err), .intr(intr), .m_bus_req(m_bus_req), .m_bus_wen(m_bus_wen),
      .m_bus_mode(m_bus_mode), .m_bus_addr(m_bus_addr), .m_bus_dat_o(m_bus_dat_o),
      .m_bus_dat_i(m_bus_dat_i), .m_bus_ready(m_bus_ready)
   );

   function automatic logic [31:0] pattern(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [31:0] rd_mem(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : pattern(a);
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Slave: read data appears the cycle after accept, garbage otherwise.
   always @(posedge clk) begin
      if (m_bus_req && m_bus_ready) begin
         if (m_bus_wen) mem[m_bus_addr] = m_bus_dat_o;
         else m_bus_dat_i <= rd_mem(m_bus_addr);
      end else begin
         m_bus_dat_i <= $urandom;
      end
   end

   always @(posedge clk) begin
      #1;
      case (rmode)
         0: ready_r = 1'b1;
         1: ready_r = 1'($urandom_range(0, 1));
         default: ready_r = 1'b0;
      endcase
   end
   assign m_bus_ready = ready_r & ~force_low;

   // Monitor: pulse counters, hold-stability and scoreboard.
   logic        pend = 1'b0;
   logic        p_wen;
   logic [31:0] p_addr, p_dat;
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (m_bus_req) req_cyc++;
      if (busy) busy_cyc++;
      if (pend && m_bus_req) begin
         check("hold_addr", m_bus_addr, p_addr);
         check("hold_wen", m_bus_wen, p_wen);
         check("hold_dat", m_bus_dat_o, p_dat);
      end
      pend   = m_bus_req && !m_bus_ready;
      p_addr = m_bus_addr;
      p_wen  = m_bus_wen;
      p_dat  = m_bus_dat_o;
      if (sb_en && m_bus_req && m_bus_ready) begin
         if (sbq.size() == 0) begin
            check("sb_unexpected_accept", 1, 0);
         end else begin
            x = sbq.pop_front();
            check("sb_wen", m_bus_wen, x.wen);
            check("sb_addr", m_bus_addr, x.addr);
            if (x.wen) check("sb_wdat", m_bus_dat_o, x.dat);
         end
      end
   end

   task automatic push_words(input logic [31:0] s, input logic [31:0] d, input int n);
      for (int k = 0; k < n; k++) begin
         sbq.push_back('{wen: 1'b0, addr: s + 32'(4 * k), dat: 32'h0});
         sbq.push_back('{wen: 1'b1, addr: d + 32'(4 * k), dat: rd_mem(s + 32'(4 * k))});
      end
   endtask

   task automatic clr_counts();
      done_cnt = 0; err_cnt = 0; req_cyc = 0; busy_cyc = 0;
   endtask

   task automatic do_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                          input int maxc, output int cyc);
      bit fin;
      @(negedge clk);
      clr_counts();
      src_addr = s; dst_addr = d; len = n; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cyc = 0;
      fin = 1'b0;
      for (int k = 0; k < maxc; k++) begin
         @(negedge clk);
         cyc++;
         if (done || err) begin
            fin = 1'b1;
            break;
         end
      end
      if (!fin) check("wait_bound_expired", 0, 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic clear_intr();
      @(negedge clk) intr_clr = 1'b1;
      @(negedge clk) intr_clr = 1'b0;
   endtask

   initial begin
      int cyc;
      int wr;
      bit found;
      rst = 1'b0; start = 1'b0; abort = 1'b0; intr_clr = 1'b0;
      src_addr = '0; dst_addr = '0; len = '0;
      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_intr", intr, 0);
      check("rst_req", m_bus_req, 0);
      check("rst_wen", m_bus_wen, 0);
      check("rst_addr", m_bus_addr, 0);
      check("rst_dat_o", m_bus_dat_o, 0);
      check("rst_mode", m_bus_mode, 2'b10);
      @(negedge clk) rst = 1'b1;

      // Basic 3-word copy with ready tied high.
      push_words(32'h100, 32'h200, 3);
      do_copy(32'h100, 32'h200, 16'd3, 50, cyc);
      check("t1_done_cycle", cyc, 10);
      check("t1_done_cnt", done_cnt, 1);
      check("t1_err_cnt", err_cnt, 0);
      check("t1_intr", intr, 1);
      check("t1_busy_after", busy, 0);
      check("t1_sb_empty", sbq.size(), 0);
      for (int k = 0; k < 3; k++)
         check("t1_mem", rd_mem(32'h200 + 32'(4 * k)), pattern(32'h100 + 32'(4 * k)));

      clear_intr();
      @(negedge clk);
      check("intr_clr", intr, 0);

      // len=0 with start held into FIN: one done, no bus traffic.
      clr_counts();
      src_addr = 32'h100; dst_addr = 32'h200; len = 16'd0; start = 1'b1;
      @(negedge clk);
      check("t2_done_pulse", done, 1);
      check("t2_busy_fin", busy, 1);
      @(negedge clk);
      start = 1'b0;
      check("t2_done_low", done, 0);
      check("t2_busy_idle", busy, 0);
      repeat (3) @(negedge clk);
      check("t2_done_cnt", done_cnt, 1);
      check("t2_no_req", req_cyc, 0);
      check("t2_intr", intr, 1);

      // Misaligned source; intr stays set across the new start.
      do_copy(32'h102, 32'h200, 16'd2, 10, cyc);
      check("t3_err_cycle", cyc, 1);
      check("t3_err_cnt", err_cnt, 1);
      check("t3_busy", busy_cyc, 0);
      check("t3_no_req", req_cyc, 0);
      check("t3_no_done", done_cnt, 0);
      check("t3_intr_kept", intr, 1);
      // Misaligned destination is reported even when len==0.
      do_copy(32'h100, 32'h201, 16'd0, 10, cyc);
      check("t3b_err_cnt", err_cnt, 1);
      check("t3b_no_done", done_cnt, 0);

      clear_intr();

      // Timeout: slave never ready.
      rmode = 2;
      repeat (2) @(negedge clk);
      do_copy(32'h100, 32'h600, 16'd2, 400, cyc);
      check("t4_err_cycle", cyc, 256);
      check("t4_req_cycles", req_cyc, 255);
      check("t4_err_cnt", err_cnt, 1);
      check("t4_no_done", done_cnt, 0);
      check("t4_intr", intr, 0);
      check("t4_req_low", m_bus_req, 0);
      check("t4_busy", busy, 0);
      rmode = 1;
      repeat (2) @(negedge clk);

      // Random ready, 8 words.
      push_words(32'h800, 32'h900, 8);
      do_copy(32'h800, 32'h900, 16'd8, 400, cyc);
      check("t5_done_cnt", done_cnt, 1);
      check("t5_err_cnt", err_cnt, 0);
      check("t5_sb_empty", sbq.size(), 0);
      for (int k = 0; k < 8; k++)
         check("t5_mem", rd_mem(32'h900 + 32'(4 * k)), pattern(32'h800 + 32'(4 * k)));
      rmode = 0;
      repeat (2) @(negedge clk);

      // Source address wraps past the top of the address space.
      push_words(32'hFFFF_FFF8, 32'h300, 4);
      do_copy(32'hFFFF_FFF8, 32'h300, 16'd4, 50, cyc);
      check("t6_done_cycle", cyc, 13);
      check("t6_err_cnt", err_cnt, 0);
      check("t6_sb_empty", sbq.size(), 0);
      check("t6_mem_wrap", rd_mem(32'h30C), pattern(32'h4));

      clear_intr();

      // Abort during the second write request (slave not ready that cycle).
      push_words(32'h400, 32'h500, 1);
      sbq.push_back('{wen: 1'b0, addr: 32'h404, dat: 32'h0});
      @(negedge clk);
      clr_counts();
      src_addr = 32'h400; dst_addr = 32'h500; len = 16'd4; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wr = 0;
      found = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #2;
         if (m_bus_req && m_bus_wen) begin
            wr++;
            if (wr == 2) begin
               found = 1'b1;
               break;
            end
         end
      end
      check("t7_abort_reached", found, 1);
      abort = 1'b1;
      force_low = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      force_low = 1'b0;
      @(negedge clk);
      check("t7_busy", busy, 0);
      check("t7_req", m_bus_req, 0);
      repeat (4) @(negedge clk);
      check("t7_no_done", done_cnt, 0);
      check("t7_no_err", err_cnt, 0);
      check("t7_intr", intr, 0);
      check("t7_sb_empty", sbq.size(), 0);
      check("t7_word0", rd_mem(32'h500), pattern(32'h400));
      check("t7_word1_unwritten", mem.exists(32'h504), 0);

      // Asynchronous reset in the middle of a copy.
      sb_en = 1'b0;
      @(negedge clk);
      clr_counts();
      src_addr = 32'h100; dst_addr = 32'hA00; len = 16'd4; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("t8_req_async", m_bus_req, 0);
      check("t8_busy_async", busy, 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("t8_no_done", done_cnt, 0);
      check("t8_no_err", err_cnt, 0);
      check("t8_idle_req", m_bus_req, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

endmodule
